// File: rtl/xgmii_rx_frame_monitor.sv
// xgmii_rx_frame_monitor
//   Frame delineation and length checker for a 64-bit XGMII receive stream.
//   Opens a frame on START (0xFB, lane 0 or lane 4), accumulates the byte
//   length, and closes it on TERMINATE (0xFD) or on any error / unexpected
//   control pattern. Each close gives a one-cycle status pulse and bumps
//   either the good-frame or the bad-frame counter.
//
// Ports
//   rx_clk       : clock, all logic on rising edge
//   rx_rst       : synchronous active-high reset
//   xgmii_rxd    : XGMII data, lane n = bits [8n+7:8n]
//   xgmii_rxc    : XGMII control, bit n flags lane n as control
//   in_frame     : high while a frame is open
//   frame_done   : one-cycle pulse when a frame closes
//   frame_good   : status of the frame reported with frame_done
//   frame_len    : byte length of that frame (held between closes)
//   frame_count  : good frames seen (wraps)
//   error_count  : bad frames seen (wraps)
module xgmii_rx_frame_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_LEN    = 1526,
  parameter int MIN_LEN    = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic                  in_frame,
  output logic                  frame_done,
  output logic                  frame_good,
  output logic [15:0]           frame_len,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  error_count
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t         state_q, state_d;
  logic [15:0]    acc_q, acc_d;

  logic           start0, start4;
  logic           term_hit, tail_bad;
  logic [2:0]     term_lane;

  logic           close, close_good;
  logic [15:0]    close_len;

  // Length accumulator add that sticks at 0xFFFF.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    start0 = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
    start4 = ((xgmii_rxc == 8'hF0) || (xgmii_rxc == 8'h10)) && (xgmii_rxd[39:32] == 8'hFB);

    // TERMINATE in lane n: lanes below n are data, lane n and above are control.
    term_hit  = 1'b0;
    term_lane = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      if ((xgmii_rxc == 8'(8'hFF << n)) && (xgmii_rxd[8*n +: 8] == 8'hFD)) begin
        term_hit  = 1'b1;
        term_lane = 3'(n);
      end
    end

    // Anything but IDLE after the terminator (including 0xFE) spoils the frame.
    tail_bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (term_hit && (i > 32'(term_lane)) && (xgmii_rxd[8*i +: 8] != 8'h07))
        tail_bad = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    close      = 1'b0;
    close_good = 1'b0;
    close_len  = acc_q;

    case (state_q)
      IDLE: begin
        if (start0) begin
          state_d = DATA;
          acc_d   = 16'd7;
        end else if (start4) begin
          state_d = DATA;
          acc_d   = 16'd3;
        end
      end
      DATA: begin
        if (xgmii_rxc == 8'h00) begin
          acc_d = sat_add(acc_q, 4'd8);
        end else if (start0) begin
          // Back-to-back START: abort the open frame, open a new one.
          close = 1'b1;
          acc_d = 16'd7;
        end else if (term_hit) begin
          // The length only grows (saturating), so the oversize check can
          // be made once, at close, on the final length.
          close      = 1'b1;
          close_len  = sat_add(acc_q, {1'b0, term_lane});
          close_good = !tail_bad && (close_len >= 16'(MIN_LEN)) && (close_len <= 16'(MAX_LEN));
          state_d    = IDLE;
          acc_d      = '0;
        end else begin
          close   = 1'b1;
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      in_frame    <= 1'b0;
      frame_done  <= 1'b0;
      frame_good  <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      in_frame   <= (state_d == DATA);
      frame_done <= close;
      if (close) begin
        frame_good <= close_good;
        frame_len  <= close_len;
        if (close_good)
          frame_count <= frame_count + 1'b1;
        else
          error_count <= error_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_rx_frame_monitor.sv
// Testbench for xgmii_rx_frame_monitor: drives XGMII words and checks each
// frame_done against an expected-frame queue filled by the stimulus tasks.
module tb_xgmii_rx_frame_monitor;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [63:0] xgmii_rxd = IDLE_W;
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        in_frame, frame_done, frame_good;
  logic [15:0] frame_len;
  logic [31:0] frame_count, error_count;

  xgmii_rx_frame_monitor #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .MAX_LEN(1526),
    .MIN_LEN(64),
    .CNT_WIDTH(32)
  ) dut (
    .rx_clk(rx_clk),
    .rx_rst(rx_rst),
    .xgmii_rxd(xgmii_rxd),
    .xgmii_rxc(xgmii_rxc),
    .in_frame(in_frame),
    .frame_done(frame_done),
    .frame_good(frame_good),
    .frame_len(frame_len),
    .frame_count(frame_count),
    .error_count(error_count)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic        good;
    logic [15:0] len;
    logic        chk_len;
    logic        in_frame;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_fc = '0;
  logic [31:0] exp_ec = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(posedge rx_clk);
    #1;
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(IDLE_W, 8'hFF);
  endtask

  task automatic data_words(input int n);
    for (int i = 0; i < n; i++) drive({$urandom, $urandom}, 8'h00);
  endtask

  // START, nd data words, TERMINATE in lane tl. tail_err corrupts lane 7.
  task automatic send_frame(input bit lane4, input bit c10, input int nd, input int tl, input bit tail_err);
    logic [63:0] w;
    logic [7:0]  c;
    int          len;
    exp_t        e;
    if (lane4) drive(64'hD55555FB07070707, c10 ? 8'h10 : 8'hF0);
    else       drive(64'hD5555555555555FB, 8'h01);
    data_words(nd);
    len = (lane4 ? 3 : 7) + 8 * nd + tl;
    for (int i = 0; i < 8; i++) begin
      if (i < tl)       w[8*i +: 8] = 8'($urandom);
      else if (i == tl) w[8*i +: 8] = 8'hFD;
      else              w[8*i +: 8] = 8'h07;
    end
    if (tail_err && tl < 7) w[63:56] = 8'h00;
    c = 8'hFF << tl;
    e.good     = !tail_err && (len >= 64) && (len <= 1526);
    e.len      = 16'(len);
    e.chk_len  = 1'b1;
    e.in_frame = 1'b0;
    sb.push_back(e);
    drive(w, c);
    idle(2);
  endtask

  // Output monitor: every frame_done must match the oldest queued frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge rx_clk);
      if (!rx_rst && frame_done) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 32'(frame_done), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("frame_good", 32'(frame_good), 32'(e.good));
          if (e.chk_len) check_eq("frame_len", 32'(frame_len), 32'(e.len));
          if (e.good) exp_fc = exp_fc + 1;
          else        exp_ec = exp_ec + 1;
          check_eq("frame_count", frame_count, exp_fc);
          check_eq("error_count", error_count, exp_ec);
          check_eq("in_frame_after_close", 32'(in_frame), 32'(e.in_frame));
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [63:0] w;

    // Reset state
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    check_eq("rst_in_frame", 32'(in_frame), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_frame_good", 32'(frame_good), 0);
    check_eq("rst_frame_len", 32'(frame_len), 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_error_count", error_count, 0);
    @(posedge rx_clk);
    #1 rx_rst = 1'b0;

    // Long idle plus stray ordered set and data in IDLE: nothing happens
    idle(200);
    drive(64'h000000010000009C, 8'h01);
    data_words(2);
    idle(2);
    @(negedge rx_clk);
    check_eq("idle_in_frame", 32'(in_frame), 0);
    check_eq("idle_frame_count", frame_count, 0);
    check_eq("idle_error_count", error_count, 0);

    // in_frame while a frame is open
    drive(64'hD5555555555555FB, 8'h01);
    data_words(2);
    @(negedge rx_clk);
    check_eq("mid_in_frame", 32'(in_frame), 1);
    data_words(5);
    w = 64'h07070707_07FD_0000;
    w[15:0] = 16'($urandom);
    e = '{good: 1'b1, len: 16'd65, chk_len: 1'b1, in_frame: 1'b0};
    sb.push_back(e);
    drive(w, 8'hFC);
    idle(2);

    // Lane-4 START variants
    send_frame(1'b1, 1'b0, 8, 0, 1'b0);   // 67 good
    send_frame(1'b1, 1'b1, 8, 3, 1'b0);   // 70 good

    // 0xFE in lane 3 mid-frame
    drive(64'hD5555555555555FB, 8'h01);
    data_words(3);
    e = '{good: 1'b0, len: 16'd0, chk_len: 1'b0, in_frame: 1'b0};
    sb.push_back(e);
    w = {$urandom, $urandom};
    w[31:24] = 8'hFE;
    drive(w, 8'h08);
    idle(2);

    // Length boundaries and oversize
    send_frame(1'b0, 1'b0, 200, 0, 1'b0); // 1607 bad
    send_frame(1'b0, 1'b0, 189, 7, 1'b0); // 1526 good
    send_frame(1'b0, 1'b0, 190, 0, 1'b0); // 1527 bad
    send_frame(1'b0, 1'b0, 7, 1, 1'b0);   // 64 good
    send_frame(1'b0, 1'b0, 7, 0, 1'b0);   // 63 bad
    send_frame(1'b0, 1'b0, 5, 4, 1'b0);   // 51 bad

    // Non-IDLE byte after TERMINATE
    send_frame(1'b0, 1'b0, 7, 2, 1'b1);   // 65 but bad

    // START inside a frame: abort then a good frame
    drive(64'hD5555555555555FB, 8'h01);
    data_words(3);
    e = '{good: 1'b0, len: 16'd0, chk_len: 1'b0, in_frame: 1'b1};
    sb.push_back(e);
    send_frame(1'b0, 1'b0, 7, 2, 1'b0);   // 65 good

    check_eq("queue_drained", 32'(sb.size()), 0);

    // Reset mid-frame: dropped silently, counters cleared
    drive(64'hD5555555555555FB, 8'h01);
    data_words(3);
    @(posedge rx_clk);
    #1;
    rx_rst = 1'b1;
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    @(posedge rx_clk);
    #1 rx_rst = 1'b0;
    exp_fc = '0;
    exp_ec = '0;
    idle(5);
    @(negedge rx_clk);
    check_eq("rst_mid_in_frame", 32'(in_frame), 0);
    check_eq("rst_mid_frame_count", frame_count, 0);
    check_eq("rst_mid_error_count", error_count, 0);
    check_eq("rst_mid_frame_len", 32'(frame_len), 0);

    // Recovers after reset
    send_frame(1'b0, 1'b0, 10, 5, 1'b0);  // 92 good
    idle(2);
    check_eq("final_queue_drained", 32'(sb.size()), 0);
    check_eq("final_frame_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
